seq_pattern_checker: RTL
========================

Name: seq_pattern_checker

Overview:
- Downstream consumer of the 8-bit registered data stage (`dout` of the DFF stage).
- Watches the stream for a programmable three-byte ordered pattern, default 1 -> 2 -> 3.
- Element-to-element gap is bounded.
- Flags each completed pattern (`match`) and each broken partial pattern (`abort`), and keeps saturating counts of both for bench and status readout.

Parameters:
- DW, 8, data width.
- PAT0, 8'h01, first pattern element.
- PAT1, 8'h02, second pattern element.
- PAT2, 8'h03, third pattern element.
- MAX_GAP, 4, max consecutive non-valid cycles allowed between accepted elements (>=1).
- CNT_W, 8, width of match/abort counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- din_vld  in  1  din qualifier; element sampled only when high.
- din  in  DW  data from upstream DFF stage.
- clr  in  1  synchronous clear of counters and FSM.
- match  out  1  one-cycle pulse: full pattern accepted.
- abort  out  1  one-cycle pulse: partial pattern broken or timed out.
- state_o  out  2  current FSM state (0=IDLE, 1=S1, 2=S2).
- match_cnt  out  CNT_W  saturating count of matches.
- abort_cnt  out  CNT_W  saturating count of aborts.

Behaviour:
- Reset (rst low, async): state IDLE, gap_cnt=0; match, abort, match_cnt, abort_cnt all 0, state_o=0. Reset holds while rst is low.
- All outputs are registered. Evaluation happens at each rising edge. match/abort are high for the single cycle following the deciding edge (latency 1 from the sampled element).
- Transitions from IDLE:
  - vld & din==PAT0 -> S1.
  - Otherwise stay in IDLE; no abort.
- Transitions from S1 (PAT0 seen), in priority order:
  - vld & din==PAT1 -> S2.
  - vld & din==PAT0 -> S1 (restart; no abort).
  - vld & other -> IDLE, abort.
- Transitions from S2 (PAT0,PAT1 seen), in priority order:
  - vld & din==PAT2 -> IDLE, match (non-overlapping).
  - vld & din==PAT0 -> S1, abort.
  - vld & other -> IDLE, abort.
- Gap timer, active in S1/S2 only:
  - gap_cnt clears on every edge with vld=1 and on every state entry.
  - gap_cnt increments on each edge with vld=0.
  - If vld=0 and gap_cnt==MAX_GAP-1: -> IDLE, abort, gap_cnt=0. So at MAX_GAP=4 the 4th consecutive idle edge times out, and a valid at the 4th edge after the previous element is still accepted.
  - In IDLE, gap_cnt is held at 0.
- Counters:
  - match_cnt increments when match is set; abort_cnt increments when abort is set.
  - Both saturate at all-ones and never wrap.
- clr high at an edge:
  - state -> IDLE, gap_cnt=0, both counters=0, match=abort=0.
  - Overrides any match/abort decided that edge; the event is neither pulsed nor counted.
- match and abort are mutually exclusive in any cycle.
- din is don't-care when din_vld=0.
- Reset asserted mid-pattern discards the partial pattern with no abort pulse. After release the FSM starts in IDLE.

Test Plan:
1. Valid stream 1,2,3 on consecutive cycles -> match=1 for exactly one cycle after the edge sampling 3; match_cnt=1, abort_cnt=0, state_o=0.
2. Sequence with gaps:
   - 1, 2, three idle cycles, 3 (MAX_GAP=4) -> match, match_cnt=1.
   - Then 1 followed by four idle cycles -> abort pulse after the 4th idle edge, abort_cnt=1, state_o=0.
3. Broken and repeated elements:
   - 1,2,5 -> abort after 5, state_o=0, no match.
   - Then 1,1,2,3 -> exactly one match, no further abort; totals match_cnt=1, abort_cnt=1.
4. 1,2,1,2,3 -> abort after the second 1 (state_o=1 next cycle), then match after 3; match_cnt=1, abort_cnt=1.
5. Counter saturation and clear:
   - 260 back-to-back 1,2,3 patterns -> match_cnt holds 8'hFF.
   - clr pulse -> match_cnt=0, abort_cnt=0 next cycle.
   - clr coincident with the edge sampling 3 in S2 -> no match pulse, match_cnt stays 0.
6. Reset mid-pattern: after 1,2 (state_o=2), drive rst low between clock edges -> state_o=0 and all outputs 0 immediately. Release rst, send 3 -> no match, no abort.

Source files
------------

// File: rtl/seq_pattern_checker.sv
// Watches a qualified byte stream for an ordered three-element pattern
// with a bounded inter-element gap; flags matches/aborts and counts them.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din_vld    qualifies din; an element is sampled only when high
//   din        data from the upstream register stage
//   clr        synchronous clear of FSM, gap timer and counters
//   match      one-cycle pulse after the edge that completed the pattern
//   abort      one-cycle pulse after the edge that broke a partial pattern
//   state_o    FSM state (0=IDLE, 1=S1, 2=S2)
//   match_cnt  saturating count of matches
//   abort_cnt  saturating count of aborts
module seq_pattern_checker #(
    parameter int            DW      = 8,
    parameter logic [DW-1:0] PAT0    = 'h01,
    parameter logic [DW-1:0] PAT1    = 'h02,
    parameter logic [DW-1:0] PAT2    = 'h03,
    parameter int            MAX_GAP = 4,
    parameter int            CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic [DW-1:0]    din,
    input  logic             clr,
    output logic             match,
    output logic             abort,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_S1   = 2'd1;
    localparam logic [1:0] ST_S2   = 2'd2;

    localparam int GW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(MAX_GAP - 1);

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             match_q, match_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;

    logic hit0, hit1, hit2;
    logic timeout;

    assign hit0 = din_vld && (din == PAT0);
    assign hit1 = din_vld && (din == PAT1);
    assign hit2 = din_vld && (din == PAT2);

    // Last allowed idle edge has been used up: this idle edge expires.
    assign timeout = !din_vld && (gap_q == GAP_LAST);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        match_d = 1'b0;
        abort_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                gap_d = '0;
                if (hit0) begin
                    state_d = ST_S1;
                end
            end
            ST_S1: begin
                if (din_vld) begin
                    gap_d = '0;
                    if (hit1) begin
                        state_d = ST_S2;
                    end else if (hit0) begin
                        // Fresh first element simply restarts the pattern.
                        state_d = ST_S1;
                    end else begin
                        state_d = ST_IDLE;
                        abort_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_S2: begin
                if (din_vld) begin
                    gap_d = '0;
                    if (hit2) begin
                        // Non-overlapping: go straight back to IDLE.
                        state_d = ST_IDLE;
                        match_d = 1'b1;
                    end else if (hit0) begin
                        state_d = ST_S1;
                        abort_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        abort_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gap_d   = '0;
            end
        endcase

        // Clear wins over whatever was decided this edge.
        if (clr) begin
            state_d = ST_IDLE;
            gap_d   = '0;
            match_d = 1'b0;
            abort_d = 1'b0;
        end
    end

    always_comb begin
        match_cnt_d = match_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (clr) begin
            match_cnt_d = '0;
            abort_cnt_d = '0;
        end else begin
            if (match_d && (match_cnt_q != '1)) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
            if (abort_d && (abort_cnt_q != '1)) begin
                abort_cnt_d = abort_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            match_q     <= 1'b0;
            abort_q     <= 1'b0;
            match_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            match_q     <= match_d;
            abort_q     <= abort_d;
            match_cnt_q <= match_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign match     = match_q;
    assign abort     = abort_q;
    assign state_o   = state_q;
    assign match_cnt = match_cnt_q;
    assign abort_cnt = abort_cnt_q;

endmodule
